// File: rtl/registro_pipe_pkg.sv
// Shared definitions for the registro_pipe elastic register chain.
//   DefaultWidth    : default data width of a stage
//   DefaultResetVal : default value loaded into stage data registers on reset
//   occ_width()     : bit width needed to count 0..depth valid stages
package registro_pipe_pkg;

  localparam int unsigned DefaultWidth = 32;

  localparam logic [DefaultWidth-1:0] DefaultResetVal = '0;

  // Width of a counter that must represent every value from 0 to depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/registro_pipe_stage.sv
// Single elastic register stage with valid/ready handshake and synchronous flush.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset (valid cleared, data to RESET_VAL)
//   flush    : synchronous clear of the valid bit; data is kept
//   up_valid : upstream stage (or block input) holds a word
//   up_data  : upstream word
//   dn_ready : downstream stage (or block output) can take this stage's word
//   rdy      : this stage can take a word this cycle
//   valid    : this stage holds a word
//   data     : word held by this stage
module registro_pipe_stage
  import registro_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefaultWidth,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DefaultResetVal)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             rdy,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Empty, or the current word leaves this cycle: the ready path is purely combinational.
  assign rdy = !valid_q || dn_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (rdy) begin
      // Draining without refill clears valid but leaves the stale data in place.
      valid_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/registro_pipe.sv
// Chain of DEPTH elastic register stages with valid/ready handshake, synchronous
// flush and a registered occupancy count.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   flush     : synchronous clear of all stage valids (blocks input that cycle)
//   in_valid  : upstream word valid
//   in_data   : upstream word
//   in_ready  : block accepts in_data this cycle
//   out_valid : last stage holds a word
//   out_data  : data of the last stage
//   out_ready : downstream accepts out_data
//   occupancy : number of valid stages
module registro_pipe
  import registro_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefaultWidth,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DefaultResetVal)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int unsigned OccW = occ_width(DEPTH);

  logic [DEPTH-1:0] stg_valid;
  logic [DEPTH-1:0] stg_rdy;
  logic [DEPTH-1:0] stg_up_valid;
  logic [DEPTH-1:0] stg_dn_ready;
  logic [WIDTH-1:0] stg_up_data [DEPTH];
  logic [WIDTH-1:0] stg_data    [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign stg_up_valid[i] = in_valid;
      assign stg_up_data[i]  = in_data;
    end else begin : g_inner
      assign stg_up_valid[i] = stg_valid[i-1];
      assign stg_up_data[i]  = stg_data[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign stg_dn_ready[i] = out_ready;
    end else begin : g_mid
      assign stg_dn_ready[i] = stg_rdy[i+1];
    end

    registro_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .up_valid (stg_up_valid[i]),
      .up_data  (stg_up_data[i]),
      .dn_ready (stg_dn_ready[i]),
      .rdy      (stg_rdy[i]),
      .valid    (stg_valid[i]),
      .data     (stg_data[i])
    );
  end

  assign in_ready  = stg_rdy[0] && !flush;
  assign out_valid = stg_valid[DEPTH-1];
  assign out_data  = stg_data[DEPTH-1];

  // Occupancy tracks words entering and leaving; internal bubbles do not change it.
  logic            accept, emit;
  logic [OccW-1:0] occ_q, occ_d;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !emit) begin
      occ_d = occ_q + OccW'(1);
    end else if (emit && !accept) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: doc/registro_pipe.md
Name: registro_pipe

Overview:
- Parametrised successor to the single 32-bit register stage: a chain of DEPTH elastic register stages, each WIDTH bits wide, with valid/ready handshake, synchronous flush and an occupancy count.
- Sits between datapath units, such as a fetch→decode or ALU→writeback boundary, where back-pressure must stall the pipe without losing or duplicating words.

Parameters:
- WIDTH, 32, data width in bits (≥1)
- DEPTH, 2, number of register stages (≥1)
- RESET_VAL, 0, value loaded into every stage data register on reset (WIDTH bits)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- flush  in  1  synchronous clear of all stage valids
- in_valid  in  1  upstream word valid
- in_data  in  WIDTH  upstream word
- in_ready  out  1  block accepts in_data this cycle
- out_valid  out  1  stage DEPTH-1 holds a word
- out_data  out  WIDTH  data of stage DEPTH-1
- out_ready  in  1  downstream accepts out_data
- occupancy  out  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- One clock. The reset is asynchronous and active-low: reset=0 immediately forces all stage valid bits to 0 and all data registers to RESET_VAL, regardless of clk.
- Reset outputs: out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1.
- Release of reset takes effect at the first rising clk edge with reset=1.
- Stage i holds valid_q[i] and data_q[i]. Stage 0 is fed from the input; stage DEPTH-1 drives the outputs.
- Per-stage ready: rdy[i] = !valid_q[i] || rdy_next, where rdy_next = out_ready for the last stage and rdy[i+1] otherwise. The ready path is combinational through the chain; no skid buffer.
- in_ready = rdy[0] && !flush.
- Transfer into stage i on an edge when the upstream stage is valid and rdy[i]=1:
  - valid_q[i] <= 1
  - data_q[i] <= upstream data
- When stage i drains without a refill, valid_q[i] <= 0. data_q[i] holds its old value; it is not cleared.
- A stage with valid=1 and rdy=0 holds its data stable. out_data must not change while out_valid=1 && out_ready=0.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles input to output, provided no stall.
- Throughput: one word per cycle when out_ready is held at 1.
- Full pipe (all valid) with out_ready=1 accepts and emits simultaneously; occupancy stays DEPTH.
- Full pipe with out_ready=0: in_ready=0, contents frozen.
- Flush (sampled at the edge):
  - All valid_q <= 0 and occupancy <= 0.
  - Data registers are unchanged.
  - in_ready is 0 during the flush cycle, so no word is accepted.
  - Any handshake that completes on out_* in the flush cycle still counts as delivered downstream.
  - Flush has priority over every transfer.
- occupancy is registered and equals the popcount of valid_q after each edge. It is updated incrementally: +1 on accept without emit, −1 on emit without accept, unchanged otherwise. It never exceeds DEPTH or wraps below 0.
- Reset asserted mid-stream discards all words; no partial output is produced.
- DEPTH=1 degenerates to a single elastic register with identical port behaviour.

Decomposition:
- Shared package holds:
  - the default WIDTH (32)
  - the occupancy-width helper function (clog2 of DEPTH+1)
  - the RESET_VAL default constant
- One sub-module is natural: registro_pipe_stage, a single elastic stage (valid/data registers, ready equation, flush). It is instantiated DEPTH times in a generate loop.
- The occupancy counter lives in the top module.

Test Plan:
- Reset: hold reset=0 with in_valid=1, in_data=0xDEADBEEF and clk running → out_valid=0, out_data=0x00000000, occupancy=0, in_ready=1. Release reset → first word out DEPTH cycles after acceptance.
- Streaming (DEPTH=2): out_ready=1, push 0x1,0x2,0x3 on consecutive cycles → out_valid high from cycle 2, out_data 0x1,0x2,0x3 on consecutive cycles, occupancy peaks at 2, no bubbles.
- Back-pressure: fill DEPTH=3 with 0xA,0xB,0xC, out_ready=0 → occupancy=3, in_ready=0, out_data stays 0xA. Set out_ready=1 for one cycle → 0xA delivered, 0xD accepted in the same cycle, occupancy stays 3.
- Flush: pipe holding 0x11,0x22 with in_valid=1, in_data=0x33, flush=1 for one cycle → in_ready=0 that cycle, next cycle out_valid=0 and occupancy=0, 0x33 never emitted.
- Async reset mid-stream: assert reset=0 between clock edges while occupancy=2 → out_valid drops immediately (before the next edge), out_data=RESET_VAL.
- Randomized scoreboard (WIDTH=8, DEPTH=4, random in_valid/out_ready/rare flush, 10k cycles) → output order equals input order excluding flushed words, no duplicates, occupancy equals valid count every cycle.
